// File: rtl/cp_sequencer_89_if.sv
`default_nettype none
// +-------------------------------------------------------------------------+
// | cp_sequencer_89_if : host-side program/control bus and command outputs  |
// | Revision: 1.0                                                           |
// +-------------------------------------------------------------------------+
interface cp_sequencer_89_if #(
  parameter int AW = 6,
  parameter int IW = 32
);
  logic          prog_we;
  logic [AW-1:0] prog_addr;
  logic [IW-1:0] prog_data;
  logic          start;
  logic          abort;
  logic [31:0]   iter_count;
  logic [AW-1:0] loop_start;
  logic [23:0]   command_cp;
  logic          ins_in;
  logic          get_output;
  logic          busy;
  logic          done;
  logic          err;
  logic [31:0]   iter_left;
  logic [AW-1:0] pc;

  modport master (
    output prog_we, prog_addr, prog_data, start, abort, iter_count, loop_start,
    input  command_cp, ins_in, get_output, busy, done, err, iter_left, pc
  );

  modport slave (
    input  prog_we, prog_addr, prog_data, start, abort, iter_count, loop_start,
    output command_cp, ins_in, get_output, busy, done, err, iter_left, pc
  );
endinterface
`default_nettype wire

// File: rtl/cp_sequencer_89.sv
`default_nettype none
// +-------------------------------------------------------------------------+
// | cp_sequencer_89 : microcoded command sequencer with one hardware loop   |
// | Revision: 1.0                                                           |
// +-------------------------------------------------------------------------+
module cp_sequencer_89 #(
  parameter int AW = 6,
  parameter int IW = 32
) (
  input  wire logic        clk,
  input  wire logic        rst,
  cp_sequencer_89_if.slave bus
);
  localparam int            c_DEPTH   = 2**AW;
  localparam int            c_SW      = 30;
  localparam logic [AW-1:0] c_PC_LAST = {AW{1'b1}};

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FETCH = 3'd1,
    S_ISSUE = 3'd2,
    S_WAIT  = 3'd3,
    S_FIN   = 3'd4
  } state_t;

  state_t          r_state, w_state_nxt;
  logic [c_SW-1:0] r_ram [c_DEPTH];
  logic [c_SW-1:0] w_word;
  logic [AW-1:0]   r_pc, w_pc_nxt;
  logic [AW-1:0]   r_loop, w_loop_nxt;
  logic [31:0]     r_iter, w_iter_nxt;
  logic [3:0]      r_wcnt, w_wcnt_nxt;
  logic            r_err, w_err_nxt;
  logic            w_fetch, w_adv;
  logic [23:0]     r_cmd;
  logic [3:0]      r_wait;
  logic            r_lend, r_halt, r_ins;

  // Reserved word bits [31:30] are never stored.
  always_ff @(posedge clk) begin
    if (bus.prog_we && (r_state == S_IDLE))
      r_ram[bus.prog_addr] <= bus.prog_data[c_SW-1:0];
  end

  assign w_word = r_ram[r_pc];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_pc_nxt    = r_pc;
    w_loop_nxt  = r_loop;
    w_iter_nxt  = r_iter;
    w_wcnt_nxt  = r_wcnt;
    w_err_nxt   = r_err;
    w_fetch     = 1'b0;
    w_adv       = 1'b0;
    if (bus.abort && (r_state != S_IDLE)) begin
      w_state_nxt = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (bus.start) begin
            w_err_nxt = 1'b0;
            if (bus.iter_count != 32'd0) begin
              w_pc_nxt    = '0;
              w_iter_nxt  = bus.iter_count;
              w_loop_nxt  = bus.loop_start;
              w_state_nxt = S_FETCH;
            end else begin
              w_state_nxt = S_FIN;
            end
          end
        end
        S_FETCH: begin
          w_fetch     = 1'b1;
          w_state_nxt = S_ISSUE;
        end
        S_ISSUE: begin
          if (r_wait != 4'd0) begin
            w_wcnt_nxt  = r_wait;
            w_state_nxt = S_WAIT;
          end else begin
            w_adv = 1'b1;
          end
        end
        S_WAIT: begin
          w_wcnt_nxt = r_wcnt - 4'd1;
          if (r_wcnt <= 4'd1) w_adv = 1'b1;
        end
        S_FIN:   w_state_nxt = S_IDLE;
        default: w_state_nxt = S_IDLE;
      endcase

      // Next-pc rule: halt, loop back, loop exit, run-off, sequential.
      if (w_adv) begin
        if (r_halt) begin
          w_state_nxt = S_FIN;
        end else if (r_lend && (r_iter > 32'd1)) begin
          w_iter_nxt  = r_iter - 32'd1;
          w_pc_nxt    = r_loop;
          w_state_nxt = S_FETCH;
        end else begin
          if (r_lend && (r_iter == 32'd1)) w_iter_nxt = 32'd0;
          if (r_pc == c_PC_LAST) begin
            w_err_nxt   = 1'b1;
            w_state_nxt = S_FIN;
          end else begin
            w_pc_nxt    = r_pc + AW'(1);
            w_state_nxt = S_FETCH;
          end
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pc   <= '0;
      r_loop <= '0;
      r_iter <= '0;
      r_wcnt <= '0;
      r_err  <= 1'b0;
      r_cmd  <= '0;
      r_wait <= '0;
      r_lend <= 1'b0;
      r_halt <= 1'b0;
      r_ins  <= 1'b0;
    end else begin
      r_pc   <= w_pc_nxt;
      r_loop <= w_loop_nxt;
      r_iter <= w_iter_nxt;
      r_wcnt <= w_wcnt_nxt;
      r_err  <= w_err_nxt;
      r_ins  <= w_fetch;
      if (w_fetch) begin
        r_cmd  <= w_word[23:0];
        r_wait <= w_word[27:24];
        r_lend <= w_word[28];
        r_halt <= w_word[29];
      end
    end
  end

  assign bus.command_cp = r_cmd;
  assign bus.ins_in     = r_ins;
  assign bus.busy       = (r_state != S_IDLE);
  assign bus.done       = (r_state == S_FIN);
  assign bus.get_output = (r_state == S_FIN);
  assign bus.err        = r_err;
  assign bus.iter_left  = r_iter;
  assign bus.pc         = r_pc;
endmodule
`default_nettype wire

// File: tb/tb_cp_sequencer_89.sv
`default_nettype none
// +-------------------------------------------------------------------------+
// | tb_cp_sequencer_89 : scoreboard bench with a program-level model        |
// | Revision: 1.0                                                           |
// +-------------------------------------------------------------------------+
module tb_cp_sequencer_89;
  localparam int AW    = 6;
  localparam int DEPTH = 64;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  cp_sequencer_89_if #(.AW(AW), .IW(32)) bus ();
  cp_sequencer_89 #(.AW(AW), .IW(32)) dut (.clk(clk), .rst(rst), .bus(bus));

  typedef struct {
    bit            is_done;
    longint        cyc;
    logic [23:0]   cmd;
    bit            err;
    logic [31:0]   iter;
    logic [AW-1:0] pc;
  } exp_t;

  exp_t          sb[$];
  longint        cyc = 0;
  int            n_checks = 0;
  int            n_fail = 0;
  bit            mon_en = 1'b0;
  logic [31:0]   prog [DEPTH];
  bit            m_err = 1'b0;
  logic [31:0]   m_iter = '0;
  logic [AW-1:0] m_pc = '0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic push_ev(input bit is_done, input longint c, input logic [23:0] cmd);
    exp_t e;
    e.is_done = is_done;
    e.cyc     = c;
    e.cmd     = cmd;
    e.err     = m_err;
    e.iter    = m_iter;
    e.pc      = m_pc;
    sb.push_back(e);
  endtask

  // Program-level reference: walks the program word by word, accumulating
  // absolute cycle times (t0 = cycle in which start is sampled).
  task automatic run_model(input logic [31:0] iters, input int ls, input longint t0);
    int          p;
    logic [31:0] it;
    logic [31:0] w;
    longint      t;
    int          wt;
    m_err = 1'b0;
    if (iters == 0) begin
      push_ev(1'b1, t0 + 1, 24'h0);
      return;
    end
    p  = 0;
    it = iters;
    t  = t0 + 2;
    forever begin
      w  = prog[p];
      wt = int'(w[27:24]);
      push_ev(1'b0, t, w[23:0]);
      if (w[29]) break;
      if (w[28] && it > 1) begin
        it--;
        p = ls;
        t = t + 2 + wt;
        continue;
      end
      if (w[28] && it == 1) it = 0;
      if (p == DEPTH - 1) begin
        m_err = 1'b1;
        break;
      end
      p++;
      t = t + 2 + wt;
    end
    m_pc   = AW'(p);
    m_iter = it;
    push_ev(1'b1, t + 1 + wt, 24'h0);
  endtask

  always @(negedge clk) begin : monitor
    exp_t e;
    if (mon_en) begin
      while (sb.size() != 0 && sb[0].cyc < cyc) begin
        n_checks++;
        n_fail++;
        $display("FAIL missed_event: expected done=%0d at cycle %0d, got nothing (now %0d)",
                 sb[0].is_done, sb[0].cyc, cyc);
        void'(sb.pop_front());
      end
      if (bus.ins_in === 1'b1 || bus.done === 1'b1) begin
        if (sb.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_event: got ins_in=%0b done=%0b, expected none (cycle %0d)",
                   bus.ins_in, bus.done, cyc);
        end else begin
          e = sb.pop_front();
          check("event_is_done", 64'(bus.done), 64'(e.is_done));
          check("event_cycle", 64'(cyc), 64'(e.cyc));
          if (e.is_done) begin
            check("done_get_output", 64'(bus.get_output), 64'(1));
            check("done_ins_in", 64'(bus.ins_in), 64'(0));
            check("done_err", 64'(bus.err), 64'(e.err));
            check("done_iter_left", 64'(bus.iter_left), 64'(e.iter));
            check("done_pc", 64'(bus.pc), 64'(e.pc));
          end else begin
            check("issue_command", 64'(bus.command_cp), 64'(e.cmd));
          end
        end
      end
    end
  end

  task automatic wr(input int a, input logic [31:0] d);
    @(negedge clk);
    bus.prog_we   = 1'b1;
    bus.prog_addr = AW'(a);
    bus.prog_data = d;
    prog[a]       = d;
    @(negedge clk);
    bus.prog_we = 1'b0;
  endtask

  function automatic logic [31:0] word(input bit halt, input bit lend, input int w, input logic [23:0] cmd);
    logic [1:0] rsv;
    rsv = 2'($urandom);
    return {rsv, halt, lend, 4'(w), cmd};
  endfunction

  task automatic start_run(input logic [31:0] iters, input int ls);
    @(negedge clk);
    bus.start      = 1'b1;
    bus.iter_count = iters;
    bus.loop_start = AW'(ls);
    run_model(iters, ls, cyc);
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    int n;
    n = 0;
    while ((bus.busy !== 1'b0 || sb.size() != 0) && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (n >= budget) begin
      n_checks++;
      n_fail++;
      $display("FAIL timeout: busy=%0b pending=%0d after %0d cycles, expected idle", bus.busy, sb.size(), n);
      sb.delete();
    end
    @(negedge clk);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_command_cp"}, 64'(bus.command_cp), 64'(0));
    check({tag, "_ins_in"}, 64'(bus.ins_in), 64'(0));
    check({tag, "_get_output"}, 64'(bus.get_output), 64'(0));
    check({tag, "_busy"}, 64'(bus.busy), 64'(0));
    check({tag, "_done"}, 64'(bus.done), 64'(0));
    check({tag, "_err"}, 64'(bus.err), 64'(0));
    check({tag, "_iter_left"}, 64'(bus.iter_left), 64'(0));
    check({tag, "_pc"}, 64'(bus.pc), 64'(0));
  endtask

  initial begin
    bus.prog_we    = 1'b0;
    bus.prog_addr  = '0;
    bus.prog_data  = '0;
    bus.start      = 1'b0;
    bus.abort      = 1'b0;
    bus.iter_count = '0;
    bus.loop_start = '0;
    for (int i = 0; i < DEPTH; i++) prog[i] = '0;

    repeat (3) @(negedge clk);
    check_all_zero("reset");
    rst = 1'b0;
    mon_en = 1'b1;

    // Straight-line program
    wr(0, word(0, 0, 0, 24'h000001));
    wr(1, word(0, 0, 0, 24'h000002));
    wr(2, word(1, 0, 0, 24'h000003));
    start_run(1, 0);
    wait_idle(100);

    // Loop A B A B A B C
    wr(0, word(0, 0, 0, 24'hA0A0A0));
    wr(1, word(0, 1, 0, 24'hB0B0B0));
    wr(2, word(1, 0, 0, 24'hC0C0C0));
    start_run(3, 0);
    wait_idle(100);
    check("loop_iter_left_final", 64'(bus.iter_left), 64'(0));

    // Wait cycles
    wr(0, word(0, 0, 5, 24'h111111));
    wr(1, word(1, 0, 0, 24'h222222));
    start_run(1, 0);
    wait_idle(100);

    // Start and program write while busy are ignored
    start_run(1, 0);
    @(negedge clk);
    bus.start      = 1'b1;
    bus.iter_count = 32'd7;
    bus.prog_we    = 1'b1;
    bus.prog_addr  = AW'(1);
    bus.prog_data  = 32'h2000_DEAD;
    @(negedge clk);
    bus.start   = 1'b0;
    bus.prog_we = 1'b0;
    wait_idle(100);
    start_run(1, 0);
    wait_idle(100);

    // Abort during WAIT
    start_run(1, 0);
    repeat (3) @(negedge clk);
    bus.abort = 1'b1;
    sb.delete();
    @(negedge clk);
    bus.abort = 1'b0;
    check("abort_busy", 64'(bus.busy), 64'(0));
    check("abort_ins_in", 64'(bus.ins_in), 64'(0));
    check("abort_done", 64'(bus.done), 64'(0));
    check("abort_pc_hold", 64'(bus.pc), 64'(0));
    check("abort_iter_hold", 64'(bus.iter_left), 64'(1));
    m_pc = '0;
    m_iter = 32'd1;
    repeat (12) @(negedge clk);

    // Run off the end of RAM, then zero-count start clears err
    for (int i = 0; i < DEPTH; i++) wr(i, word(0, 0, 0, 24'($urandom)));
    start_run(1, 0);
    wait_idle(300);
    check("runoff_err_sticky", 64'(bus.err), 64'(1));
    start_run(0, 0);
    wait_idle(20);
    check("zero_count_err_cleared", 64'(bus.err), 64'(0));

    // Randomized programs
    for (int r = 0; r < 12; r++) begin
      for (int i = 0; i < DEPTH; i++)
        wr(i, word(($urandom % 12) == 0, ($urandom % 8) == 0, int'($urandom_range(0, 3)), 24'($urandom)));
      start_run(32'($urandom_range(0, 4)), int'($urandom_range(0, DEPTH - 1)));
      wait_idle(3000);
    end

    // Asynchronous reset mid-loop, then rerun from pc 0
    wr(0, word(0, 0, 1, 24'hA0A0A0));
    wr(1, word(0, 1, 0, 24'hB0B0B0));
    wr(2, word(1, 0, 0, 24'hC0C0C0));
    start_run(50, 0);
    repeat (15) @(negedge clk);
    mon_en = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    check_all_zero("async_reset");
    sb.delete();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    m_pc = '0;
    m_iter = '0;
    m_err = 1'b0;
    mon_en = 1'b1;
    start_run(2, 0);
    wait_idle(100);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
`default_nettype wire

// File: doc/cp_sequencer_89.md
Name: cp_sequencer_89

Overview:
- Microcoded instruction sequencer for the 89-bit cryptoprocessor (ADD/SUB/MUL+RED datapath behind the 24-bit command bus).
- Holds a small program RAM of command words and issues them one at a time on the `command_cp` / `ins_in` interface.
- Supports a single hardware loop with a 32-bit iteration counter, so a VDF isogeny-step body repeats N times without host involvement.
- Sits between the host/test controller and the cryptoprocessor wrapper; operand load/unload via `data_en` / `din` stays with the host.

Parameters:
- AW, 6, program RAM address width (DEPTH = 2**AW words).
- IW, 32, program word width; fixed layout below.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous active-high reset.
- prog_we  in  1  program RAM write strobe.
- prog_addr  in  AW  program write address.
- prog_data  in  IW  program word.
- start  in  1  one-cycle start pulse.
- abort  in  1  synchronous abort.
- iter_count  in  32  loop iteration count, sampled on accepted start.
- loop_start  in  AW  loop body first address, sampled on accepted start.
- command_cp  out  24  command to cryptoprocessor.
- ins_in  out  1  command valid strobe.
- get_output  out  1  one-cycle pulse requesting result readout.
- busy  out  1  high from accepted start until return to IDLE.
- done  out  1  one-cycle completion pulse.
- err  out  1  sticky: program ran off end of RAM; cleared by next accepted start.
- iter_left  out  32  remaining iterations.
- pc  out  AW  current program counter.

Behaviour:
- **Program word layout:**
  - [23:0] command.
  - [27:24] W, extra wait cycles after issue (0–15).
  - [28] LOOP_END.
  - [29] HALT.
  - [31:30] reserved, ignored.
- **Reset:** all outputs 0; FSM in IDLE. RAM contents are not reset.
- **RAM write rules:**
  - Writes occur only when busy=0; writes while busy are dropped.
  - A read of the address written in the same cycle returns the old data; the RAM is not observed in IDLE.
- **FSM states:** IDLE, FETCH, ISSUE, WAIT, FIN.
- **IDLE:**
  - start=1 with iter_count≠0: pc←0, iter_left←iter_count, loop reg←loop_start, err←0, busy←1, go FETCH.
  - start=1 with iter_count=0: busy←1, go FIN (no commands issued).
  - start while busy is ignored.
- **FETCH:** IR←RAM[pc]; go ISSUE.
- **ISSUE:** registered outputs ins_in=1 and command_cp=IR[23:0] for exactly this cycle. Then:
  - if W≠0: wcnt←W, go WAIT;
  - else apply next-pc rule.
- **WAIT:**
  - Decrement wcnt.
  - When wcnt reaches 1, apply next-pc rule on the following edge (W extra cycles total).
  - ins_in=0 throughout.
- **Next-pc rule, in priority order:**
  1. HALT → FIN.
  2. LOOP_END and iter_left>1 → iter_left−1, pc←loop reg, FETCH.
  3. LOOP_END and iter_left=1 → iter_left←0, then fall through to rule 4.
  4. pc=DEPTH−1 → err←1, FIN (no wrap).
  5. Otherwise pc+1, FETCH.
- **command_cp between issues:** holds last value; ins_in is the only qualifier.
- **FIN:** done=1 and get_output=1 for one cycle, busy←0, go IDLE.
- **Latency:**
  - Accepted start → first ins_in: 2 cycles.
  - Issue-to-issue spacing: 2+W cycles.
  - Final issue → done: 1+W cycles.
- **abort (any state other than IDLE):** next state IDLE, busy=0, ins_in=0, no done/get_output pulse; iter_left and pc hold. abort in IDLE has no effect.
- **Simultaneous events:**
  - abort and start together in IDLE: start wins.
  - Async rst overrides everything, mid-operation included.
- **Loop bounds:** loop_start ≥ address of the LOOP_END word is allowed; behaviour is defined by the same rules (a forward jump).

Test Plan:
- **Straight-line:** program 3 words, W=0, HALT on word 2; start (iter_count=1) → ins_in at cycles 2, 4, 6 with commands 0x000001/2/3; done at cycle 7; iter_left=1.
- **Loop:**
  - Program: word0 cmd A; word1 cmd B + LOOP_END; word2 cmd C + HALT.
  - Stimulus: loop_start=0, iter_count=3.
  - Expected: issue sequence A B A B A B C (7 issues); done once; iter_left=0.
- **Waits:** word0 W=5, word1 HALT W=0 → ins_in spacing 7 cycles; done 1 cycle after second issue.
- **Run-off/zero count:**
  - Fill all 64 words with no HALT → 64 issues, err=1, done pulse.
  - Then start with iter_count=0 → done after 1 cycle, 0 issues, err cleared.
- **Abort/ignore:**
  - abort during WAIT → busy=0 next cycle, no done.
  - start pulse and prog_we while busy → ignored; RAM unchanged on readback.
- **Reset mid-loop:** assert rst asynchronously mid-loop → all outputs 0 immediately; after release, a restart reruns the program from pc=0.
